// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait,
      StHold
   } fetch_state_e;

   localparam logic [1:0] FAULT_NONE     = 2'd0;
   localparam logic [1:0] FAULT_MISALIGN = 2'd1;
   localparam logic [1:0] FAULT_BUS      = 2'd2;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'd3;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_INST_RV = 32'h0000_0013;

endpackage

// File: rtl/if_timeout_counter.sv
// Clearable up-counter for the fetch response timeout; o_tc flags TIMEOUT_CYCLES-1.
module if_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] TermCnt = CntW'(TIMEOUT_CYCLES - 1);

   logic [CntW-1:0] r_cnt;

   // Holds at terminal count so a stray enable can never wrap it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && !o_tc) begin
         r_cnt <= r_cnt + CntW'(1);
      end
   end

   assign o_tc = (r_cnt == TermCnt);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: requests pc_i from instruction memory and hands the word to decode.
module if_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] NOP_INST       = fetch_pkg::NOP_INST_RV
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [31:0] pc_i,
   input  logic        fetch_en,
   input  logic        flush,
   output logic        stall_o,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [1:0]  fault_o
);

   fetch_state_e r_state, w_state_d;
   logic [31:0]  r_addr, w_addr_d;
   logic [31:0]  r_inst, w_inst_d;
   logic [31:0]  r_inst_pc, w_inst_pc_d;
   logic [1:0]   r_fault, w_fault_d;
   logic         r_drop, w_drop_d;
   logic         r_req_valid, r_inst_valid;
   logic         w_accept, w_cnt_clr, w_cnt_en, w_tc;

   if_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk  (clk),
      .rstn (rstn),
      .i_clr(w_cnt_clr),
      .i_en (w_cnt_en),
      .o_tc (w_tc)
   );

   always_comb begin
      w_state_d   = r_state;
      w_addr_d    = r_addr;
      w_inst_d    = r_inst;
      w_inst_pc_d = r_inst_pc;
      w_fault_d   = r_fault;
      w_drop_d    = r_drop;
      w_accept    = 1'b0;
      w_cnt_clr   = 1'b0;
      w_cnt_en    = 1'b0;

      unique case (r_state)
         StIdle: w_accept = fetch_en && !flush;
         StReq: begin
            // The request cannot be withdrawn; remember to discard its response instead.
            if (flush) w_drop_d = 1'b1;
            if (imem_req_ready) begin
               w_state_d = StWait;
               w_cnt_clr = 1'b1;
            end
         end
         StWait: begin
            w_cnt_en = 1'b1;
            if (imem_rsp_valid || w_tc) begin
               if (r_drop || flush) begin
                  w_state_d = StIdle;
                  w_drop_d  = 1'b0;
               end else begin
                  w_state_d   = StHold;
                  w_inst_pc_d = r_addr;
                  if (imem_rsp_valid) begin
                     w_fault_d = imem_rsp_err ? FAULT_BUS : FAULT_NONE;
                     w_inst_d  = imem_rsp_err ? NOP_INST : imem_rsp_data;
                  end else begin
                     w_fault_d = FAULT_TIMEOUT;
                     w_inst_d  = NOP_INST;
                  end
               end
            end else if (flush) begin
               w_drop_d = 1'b1;
            end
         end
         StHold: begin
            if (flush) begin
               w_state_d = StIdle;
               w_inst_d  = NOP_INST;
            end else if (inst_ready) begin
               w_state_d = StIdle;
               w_accept  = fetch_en;
            end
         end
         default: w_state_d = StIdle;
      endcase

      if (w_accept) begin
         if (pc_i[1:0] == 2'b00) begin
            w_state_d = StReq;
            w_addr_d  = pc_i;
         end else begin
            w_state_d   = StHold;
            w_inst_d    = NOP_INST;
            w_fault_d   = FAULT_MISALIGN;
            w_inst_pc_d = pc_i;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= StIdle;
         r_addr       <= '0;
         r_inst       <= NOP_INST;
         r_inst_pc    <= '0;
         r_fault      <= FAULT_NONE;
         r_drop       <= 1'b0;
         r_req_valid  <= 1'b0;
         r_inst_valid <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_addr       <= w_addr_d;
         r_inst       <= w_inst_d;
         r_inst_pc    <= w_inst_pc_d;
         r_fault      <= w_fault_d;
         r_drop       <= w_drop_d;
         r_req_valid  <= (w_state_d == StReq);
         r_inst_valid <= (w_state_d == StHold);
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_addr      = r_addr;
   assign inst_valid     = r_inst_valid;
   assign inst_o         = r_inst;
   assign inst_pc_o      = r_inst_pc;
   assign fault_o        = r_fault;
   // PC may advance in the same cycle decode takes the held instruction.
   assign stall_o = (r_state != StIdle) && !((r_state == StHold) && inst_ready);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized transaction-level bench for if_fetch_unit with a latency/result reference model.
module tb_if_fetch_unit;

   localparam int unsigned T   = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] pc_i;
   logic        fetch_en, flush;
   logic        stall_o;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic [31:0] inst_o, inst_pc_o;
   logic        inst_valid, inst_ready;
   logic [1:0]  fault_o;

   int n_checks = 0;
   int n_errors = 0;

   if_fetch_unit #(
      .TIMEOUT_CYCLES(T)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .pc_i          (pc_i),
      .fetch_en      (fetch_en),
      .flush         (flush),
      .stall_o       (stall_o),
      .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready),
      .imem_addr     (imem_addr),
      .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data (imem_rsp_data),
      .imem_rsp_err  (imem_rsp_err),
      .inst_o        (inst_o),
      .inst_pc_o     (inst_pc_o),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .fault_o       (fault_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_valid"}, 32'(inst_valid), 32'd0);
      check_eq({tag, "_req"}, 32'(imem_req_valid), 32'd0);
      check_eq({tag, "_stall"}, 32'(stall_o), 32'd0);
   endtask

   function automatic logic [31:0] gen_pc();
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
      return v;
   endfunction

   // Caller drives fetch_en=1/pc_i=pc for cycle 0 before calling.
   // flush_at: 0 none, 1 flush on first REQ cycle, 2 flush on HOLD release.
   task automatic run_fetch(input logic [31:0] pc, input int rd, input int dd, input logic err,
                            input logic [31:0] data, input int flush_at, input int hold,
                            input logic chain, input logic [31:0] next_pc);
      logic [31:0] exp_inst, exp_pc;
      logic [1:0]  exp_fault;
      int          done_k, hold_n;
      logic        aligned;
      aligned = (pc[1:0] == 2'b00);
      done_k  = 0;
      step();
      fetch_en   = 1'b0;
      inst_ready = 1'b0;
      exp_pc     = pc;
      if (!aligned) begin
         exp_inst  = NOP;
         exp_fault = 2'd1;
         check_eq("mis_req", 32'(imem_req_valid), 32'd0);
      end else begin
         for (int i = 0; i <= rd; i++) begin
            imem_req_ready = (i == rd);
            flush          = (flush_at == 1) && (i == 0);
            check_eq("req_valid", 32'(imem_req_valid), 32'd1);
            check_eq("req_addr", imem_addr, pc);
            check_eq("req_ivalid", 32'(inst_valid), 32'd0);
            check_eq("req_stall", 32'(stall_o), 32'd1);
            step();
         end
         imem_req_ready = 1'b0;
         flush          = 1'b0;
         // A response on the terminal WAIT cycle still beats the timeout.
         done_k = (dd < int'(T)) ? dd : int'(T) - 1;
         for (int k = 0; k <= done_k; k++) begin
            imem_rsp_valid = (k == dd);
            imem_rsp_data  = data;
            imem_rsp_err   = err;
            check_eq("wait_ivalid", 32'(inst_valid), 32'd0);
            check_eq("wait_req", 32'(imem_req_valid), 32'd0);
            check_eq("wait_stall", 32'(stall_o), 32'd1);
            step();
         end
         imem_rsp_valid = 1'b0;
         if (flush_at == 1) begin
            check_idle("drop");
            for (int k = done_k + 1; k <= dd; k++) begin
               imem_rsp_valid = (k == dd);
               step();
               check_idle("drop_late");
            end
            imem_rsp_valid = 1'b0;
            return;
         end
         if (dd < int'(T)) begin
            exp_fault = err ? 2'd2 : 2'd0;
            exp_inst  = err ? NOP : data;
         end else begin
            exp_fault = 2'd3;
            exp_inst  = NOP;
         end
      end
      hold_n = hold;
      if (aligned && (dd - done_k) > hold_n) hold_n = dd - done_k;
      for (int h = 0; h <= hold_n; h++) begin
         check_eq("hold_valid", 32'(inst_valid), 32'd1);
         check_eq("hold_inst", inst_o, exp_inst);
         check_eq("hold_fault", 32'(fault_o), 32'(exp_fault));
         check_eq("hold_pc", inst_pc_o, exp_pc);
         if (h < hold_n) begin
            imem_rsp_valid = aligned && (done_k + 1 + h == dd);
            imem_rsp_data  = ~data;
            imem_rsp_err   = 1'b0;
            #1;
            check_eq("hold_stall", 32'(stall_o), 32'd1);
            step();
            imem_rsp_valid = 1'b0;
         end
      end
      if (flush_at == 2) begin
         flush      = 1'b1;
         fetch_en   = 1'b1;
         pc_i       = next_pc;
         inst_ready = 1'($urandom_range(0, 1));
         step();
         flush      = 1'b0;
         fetch_en   = 1'b0;
         inst_ready = 1'b0;
         check_idle("flush_hold");
         return;
      end
      inst_ready = 1'b1;
      fetch_en   = chain;
      pc_i       = next_pc;
      #1;
      check_eq("rel_stall", 32'(stall_o), 32'd0);
      if (!chain) begin
         step();
         inst_ready = 1'b0;
         check_idle("rel");
      end
   endtask

   initial begin
      logic [31:0] cur_pc, nxt_pc;
      logic        chained, chain;
      int          fa;
      rstn           = 1'b0;
      pc_i           = '0;
      fetch_en       = 1'b0;
      flush          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      imem_rsp_err   = 1'b0;
      inst_ready     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_idle("rst");
      check_eq("rst_inst", inst_o, NOP);
      check_eq("rst_ipc", inst_pc_o, 32'd0);
      check_eq("rst_addr", imem_addr, 32'd0);
      check_eq("rst_fault", 32'(fault_o), 32'd0);
      rstn = 1'b1;
      step();

      // Directed scenarios
      pc_i = 32'h10; fetch_en = 1'b1;
      run_fetch(32'h10, 0, 0, 1'b0, 32'h0050_0093, 0, 0, 1'b0, 32'h0);
      pc_i = 32'h6; fetch_en = 1'b1;
      run_fetch(32'h6, 0, 0, 1'b0, 32'h0, 0, 1, 1'b0, 32'h0);
      pc_i = 32'h100; fetch_en = 1'b1;
      run_fetch(32'h100, 4, 1, 1'b1, 32'h1234_5678, 0, 0, 1'b0, 32'h0);
      pc_i = 32'h200; fetch_en = 1'b1;
      run_fetch(32'h200, 0, int'(T) + 1, 1'b0, 32'h0BAD_0BAD, 0, 3, 1'b0, 32'h0);
      pc_i = 32'h300; fetch_en = 1'b1;
      run_fetch(32'h300, 3, 1, 1'b0, 32'hDEAD_BEEF, 1, 0, 1'b0, 32'h0);
      pc_i = 32'h20; fetch_en = 1'b1;
      run_fetch(32'h20, 0, 2, 1'b0, 32'hCAFE_0001, 0, 5, 1'b0, 32'h0);
      pc_i = 32'h30; fetch_en = 1'b1;
      run_fetch(32'h30, 0, 0, 1'b0, 32'h1111_0000, 0, 0, 1'b1, 32'h34);
      run_fetch(32'h34, 1, 0, 1'b0, 32'h2222_0000, 0, 0, 1'b0, 32'h0);
      pc_i = 32'h40; fetch_en = 1'b1;
      run_fetch(32'h40, 0, 0, 1'b0, 32'h3333_0000, 2, 1, 1'b0, 32'h44);

      // Randomized transactions
      chained = 1'b0;
      nxt_pc  = gen_pc();
      for (int t = 0; t < 40; t++) begin
         cur_pc = nxt_pc;
         nxt_pc = gen_pc();
         fa     = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 9) == 0) ? 2 : 0);
         chain  = (fa == 0) && (t != 39) && ($urandom_range(0, 1) == 1);
         if (!chained) begin
            pc_i     = cur_pc;
            fetch_en = 1'b1;
         end
         run_fetch(cur_pc, $urandom_range(0, 3), $urandom_range(0, T + 2),
                   1'($urandom_range(0, 4) == 0), $urandom, fa, $urandom_range(0, 3),
                   chain, nxt_pc);
         chained = chain;
      end

      // Asynchronous reset during WAIT, then a stale response
      pc_i = 32'h80; fetch_en = 1'b1;
      step();
      fetch_en = 1'b0; imem_req_ready = 1'b1;
      step();
      imem_req_ready = 1'b0;
      step();
      #2;
      rstn = 1'b0;
      #1;
      check_idle("arst");
      check_eq("arst_inst", inst_o, NOP);
      check_eq("arst_addr", imem_addr, 32'd0);
      check_eq("arst_fault", 32'(fault_o), 32'd0);
      @(posedge clk);
      #1;
      rstn           = 1'b1;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hFEED_FACE;
      step();
      imem_rsp_valid = 1'b0;
      check_idle("stale");
      step();
      check_idle("stale2");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
